// File: rtl/prog_loader.sv
// Byte-stream program loader: takes a length byte, N 16-bit words (high byte first) and
// an XOR checksum, writes the words to instruction memory, then starts the processor.
module prog_loader #(
   parameter logic [7:0] BASE_ADDR = 8'h00
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   input  logic        reload,
   output logic        mem_we,
   output logic [7:0]  mem_addr,
   output logic [15:0] mem_wdata,
   output logic        start,
   output logic        enable,
   output logic        done,
   output logic        err
);

   localparam logic [2:0] ST_LEN  = 3'd0;
   localparam logic [2:0] ST_HI   = 3'd1;
   localparam logic [2:0] ST_LO   = 3'd2;
   localparam logic [2:0] ST_CHK  = 3'd3;
   localparam logic [2:0] ST_GO   = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;
   localparam logic [2:0] ST_ERR  = 3'd6;

   // Handshake: a byte moves on a rising edge only when rx_valid and rx_ready are both 1;
   // rx_ready is registered and depends only on the loader state, never on rx_valid.
   logic [2:0]  state_q, state_d;
   logic        rx_ready_q, rx_ready_d;
   logic [8:0]  n_q, n_d;
   logic [8:0]  idx_q, idx_d;
   logic [7:0]  hi_q, hi_d;
   logic [7:0]  xor_q, xor_d;
   logic        mem_we_q, mem_we_d;
   logic [7:0]  mem_addr_q, mem_addr_d;
   logic [15:0] mem_wdata_q, mem_wdata_d;
   logic        start_q, start_d;
   logic        enable_q, enable_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        xfer;

   assign xfer = rx_valid & rx_ready_q;

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      idx_d       = idx_q;
      hi_d        = hi_q;
      xor_d       = xor_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      start_d     = 1'b0;
      enable_d    = enable_q;
      done_d      = done_q;
      err_d       = err_q;

      case (state_q)
         ST_LEN: if (xfer) begin
            n_d     = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            xor_d   = xor_q ^ rx_data;
            state_d = ST_HI;
         end
         ST_HI: if (xfer) begin
            hi_d    = rx_data;
            xor_d   = xor_q ^ rx_data;
            state_d = ST_LO;
         end
         ST_LO: if (xfer) begin
            xor_d       = xor_q ^ rx_data;
            mem_we_d    = 1'b1;
            mem_wdata_d = {hi_q, rx_data};
            mem_addr_d  = BASE_ADDR + idx_q[7:0];
            idx_d       = idx_q + 9'd1;
            state_d     = ((idx_q + 9'd1) < n_q) ? ST_HI : ST_CHK;
         end
         ST_CHK: if (xfer) begin
            if (rx_data == xor_q) begin
               start_d  = 1'b1;
               enable_d = 1'b1;
               done_d   = 1'b1;
               state_d  = ST_GO;
            end else begin
               err_d    = 1'b1;
               state_d  = ST_ERR;
            end
         end
         ST_GO: state_d = ST_DONE;
         ST_DONE, ST_ERR: if (reload) begin
            done_d     = 1'b0;
            err_d      = 1'b0;
            enable_d   = 1'b0;
            xor_d      = 8'h00;
            idx_d      = 9'd0;
            mem_addr_d = BASE_ADDR;
            state_d    = ST_LEN;
         end
         default: state_d = ST_LEN;
      endcase

      rx_ready_d = (state_d == ST_LEN) || (state_d == ST_HI) ||
                   (state_d == ST_LO)  || (state_d == ST_CHK);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= ST_LEN;
         rx_ready_q  <= 1'b0;
         n_q         <= 9'd0;
         idx_q       <= 9'd0;
         hi_q        <= 8'h00;
         xor_q       <= 8'h00;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= BASE_ADDR;
         mem_wdata_q <= 16'h0000;
         start_q     <= 1'b0;
         enable_q    <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rx_ready_q  <= rx_ready_d;
         n_q         <= n_d;
         idx_q       <= idx_d;
         hi_q        <= hi_d;
         xor_q       <= xor_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         start_q     <= start_d;
         enable_q    <= enable_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign rx_ready  = rx_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign start     = start_q;
   assign enable    = enable_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 00 and FE) share one byte stream and are
// checked every cycle against write queues computed from the load format.
module tb_prog_loader;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset, rx_valid, reload;
   logic [7:0] rx_data;

   logic        rx_ready0, mem_we0, start0, enable0, done0, err0;
   logic [7:0]  mem_addr0;
   logic [15:0] mem_wdata0;
   logic        rx_ready1, mem_we1, start1, enable1, done1, err1;
   logic [7:0]  mem_addr1;
   logic [15:0] mem_wdata1;

   prog_loader #(.BASE_ADDR(8'h00)) dut0 (
      .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready0), .reload(reload), .mem_we(mem_we0), .mem_addr(mem_addr0),
      .mem_wdata(mem_wdata0), .start(start0), .enable(enable0), .done(done0), .err(err0));

   prog_loader #(.BASE_ADDR(8'hFE)) dut1 (
      .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready1), .reload(reload), .mem_we(mem_we1), .mem_addr(mem_addr1),
      .mem_wdata(mem_wdata1), .start(start1), .enable(enable1), .done(done1), .err(err1));

   int checks = 0;
   int failures = 0;

   logic [23:0] exp_q0[$];
   logic [23:0] exp_q1[$];
   logic [7:0]  bytes[$];
   logic [7:0]  model_xor;
   bit          model_good;
   int          exp_starts = 0;
   int          starts0 = 0, starts1 = 0;
   logic        start0_prev = 1'b0, start1_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Per-cycle compare: every write must match the head of the expected queue.
   always @(negedge clock) begin
      logic [23:0] e;
      if (mem_we0) begin
         if (exp_q0.size() == 0) begin
            checks++; failures++;
            $display("FAIL dut0 unexpected write actual=%0h%04h expected=none", mem_addr0, mem_wdata0);
         end else begin
            e = exp_q0.pop_front();
            check("dut0 write", {mem_addr0, mem_wdata0}, e);
         end
      end
      if (mem_we1) begin
         if (exp_q1.size() == 0) begin
            checks++; failures++;
            $display("FAIL dut1 unexpected write actual=%0h%04h expected=none", mem_addr1, mem_wdata1);
         end else begin
            e = exp_q1.pop_front();
            check("dut1 write", {mem_addr1, mem_wdata1}, e);
         end
      end
      if (start0) begin
         starts0++;
         check("dut0 start single cycle", start0_prev, 0);
         check("dut0 start with done/enable", {done0, enable0}, 2'b11);
      end
      if (start1) begin
         starts1++;
         check("dut1 start single cycle", start1_prev, 0);
      end
      if (err0) check("dut0 err exclusive", {enable0, done0, start0}, 0);
      if (err1) check("dut1 err exclusive", {enable1, done1, start1}, 0);
      start0_prev = start0;
      start1_prev = start1;
   end

   // Reference: from the byte list, the words whose low byte was sent get written
   // at base+index mod 256; a complete load with matching XOR starts the processor.
   task automatic model_load(input int n_sent);
      int nw;
      nw = (bytes[0] == 8'h00) ? 256 : int'(bytes[0]);
      model_xor = 8'h00;
      for (int k = 0; k <= 2 * nw; k++) model_xor ^= bytes[k];
      for (int w = 0; w < nw; w++) begin
         if (2 + 2 * w < n_sent) begin
            exp_q0.push_back({8'(8'h00 + w), bytes[1 + 2 * w], bytes[2 + 2 * w]});
            exp_q1.push_back({8'(8'hFE + w), bytes[1 + 2 * w], bytes[2 + 2 * w]});
         end
      end
      model_good = (bytes[2 * nw + 1] == model_xor);
      if (n_sent == bytes.size() && model_good) exp_starts++;
   endtask

   task automatic make_load(input int nw, input bit bad);
      logic [7:0] x, b;
      bytes.delete();
      x = 8'(nw);
      bytes.push_back(x);
      for (int i = 0; i < 2 * (nw == 0 ? 256 : nw); i++) begin
         b = 8'($urandom_range(0, 255));
         bytes.push_back(b);
         x ^= b;
      end
      bytes.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit rnd_reload);
      int n;
      rx_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         reload  = rnd_reload && ($urandom_range(0, 2) == 0);
         rx_data = 8'($urandom_range(0, 255));
         @(negedge clock);
      end
      reload   = 1'b0;
      rx_valid = 1'b1;
      rx_data  = b;
      n = 0;
      while (!rx_ready0 && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!rx_ready0) begin
         checks++; failures++;
         $display("FAIL rx_ready timeout actual=0 required=1 byte=%0h", b);
      end else begin
         check("dut1 ready with dut0", rx_ready1, 1);
         @(negedge clock);
      end
      rx_valid = 1'b0;
   endtask

   task automatic send_stream(input int n_sent, input int gmin, input int gmax, input bit rr);
      for (int k = 0; k < n_sent; k++)
         send_byte(bytes[k], (k == 0) ? 0 : int'($urandom_range(gmax, gmin)), rr);
   endtask

   task automatic finish_check(input bit good);
      repeat (3) @(negedge clock);
      check("dut0 done", done0, good);
      check("dut0 enable", enable0, good);
      check("dut0 err", err0, !good);
      check("dut0 rx_ready idle", rx_ready0, 0);
      check("dut1 done", done1, good);
      check("dut1 err", err1, !good);
      check("dut0 writes drained", exp_q0.size(), 0);
      check("dut1 writes drained", exp_q1.size(), 0);
      check("dut0 start count", starts0, exp_starts);
      check("dut1 start count", starts1, exp_starts);
   endtask

   task automatic do_reload();
      reload = 1'b1;
      @(negedge clock);
      reload = 1'b0;
      check("reload done clear", {done0, done1}, 0);
      check("reload err clear", {err0, err1}, 0);
      check("reload enable clear", {enable0, enable1}, 0);
      check("reload rx_ready", {rx_ready0, rx_ready1}, 2'b11);
      check("reload addr0", mem_addr0, 8'h00);
      check("reload addr1", mem_addr1, 8'hFE);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " flags0"}, {rx_ready0, mem_we0, start0, enable0, done0, err0}, 0);
      check({tag, " flags1"}, {rx_ready1, mem_we1, start1, enable1, done1, err1}, 0);
      check({tag, " addr0"}, mem_addr0, 8'h00);
      check({tag, " addr1"}, mem_addr1, 8'hFE);
      check({tag, " wdata"}, {mem_wdata0, mem_wdata1}, 0);
   endtask

   task automatic basic_bytes(input logic [7:0] last);
      bytes = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, last};
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; rx_valid = 1'b0; reload = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clock);
      check_reset_vals("reset");
      reset = 1'b1;
      @(negedge clock);
      check("ready after reset", {rx_ready0, rx_ready1}, 2'b11);

      // Basic load; XOR of 02,12,34,AB,CD is 42.
      basic_bytes(8'h42);
      model_load(6);
      check("model xor basic", model_xor, 8'h42);
      check("model word0", exp_q0[0], 24'h001234);
      check("model word1", exp_q0[1], 24'h01ABCD);
      check("model word0 base FE", exp_q1[0], 24'hFE1234);
      send_stream(6, 0, 0, 0);
      finish_check(1);
      do_reload();

      // Bad checksum.
      basic_bytes(8'h41);
      model_load(6);
      send_stream(6, 0, 0, 0);
      finish_check(0);
      do_reload();

      // Stalled stream: three idle cycles between bytes.
      basic_bytes(8'h42);
      model_load(6);
      send_stream(6, 3, 3, 0);
      finish_check(1);
      do_reload();

      // Single word 0F0F.
      bytes = '{8'h01, 8'h0F, 8'h0F, 8'h01};
      model_load(4);
      check("model single word", exp_q0[0], 24'h000F0F);
      send_stream(4, 0, 0, 0);
      finish_check(1);
      do_reload();

      // Three words: dut1 wraps FE, FF, 00.
      make_load(3, 0);
      model_load(bytes.size());
      check("model wrap first", exp_q1[0][23:16], 8'hFE);
      check("model wrap last", exp_q1[2][23:16], 8'h00);
      send_stream(bytes.size(), 0, 1, 0);
      finish_check(1);
      do_reload();

      // Reset after the high byte of word 1.
      basic_bytes(8'h42);
      model_load(4);
      send_stream(4, 0, 0, 0);
      reset = 1'b0;
      @(negedge clock);
      check_reset_vals("mid-load reset");
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("mid-load writes drained", exp_q0.size(), 0);
      basic_bytes(8'h42);
      model_load(6);
      send_stream(6, 0, 0, 0);
      finish_check(1);
      do_reload();

      // Random loads with stalls, ignored reloads and occasional bad checksums.
      for (int t = 0; t < 8; t++) begin
         bit bad;
         bad = ($urandom_range(0, 3) == 0);
         make_load(int'($urandom_range(1, 6)), bad);
         model_load(bytes.size());
         send_stream(bytes.size(), 0, 2, 1);
         finish_check(model_good);
         do_reload();
      end

      // Length byte 00: 256 words.
      make_load(0, 0);
      model_load(bytes.size());
      send_stream(bytes.size(), 0, 0, 0);
      finish_check(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
